// File: rtl/mod12_down_timer_if.sv
// Control/status bundle for the mod-12 countdown timer.
//
// Control semantics: this block has no valid/ready handshake. Every control
// input (load, start, stop) is a level sampled on each rising clk edge, with
// priority load > stop > start; d is consumed only on an edge where load=1,
// and auto_reload only on a step taken while q==0. bout and done are
// single-cycle registered pulses that need no acknowledge.
interface mod12_down_timer_if;
    logic       load;
    logic [3:0] d;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] q;
    logic       busy;
    logic       bout;
    logic       done;
    logic [1:0] state_dbg;

    // Driver side: owns the controls, observes count, status and FSM state.
    modport master (
        output load, d, start, stop, auto_reload,
        input  q, busy, bout, done, state_dbg
    );

    // Timer side.
    modport slave (
        input  load, d, start, stop, auto_reload,
        output q, busy, bout, done, state_dbg
    );
endinterface

// File: rtl/mod12_down_timer.sv
// Mod-12 countdown timer: q steps 11..0 once every PRESCALE clocks while
// running. At zero it either finishes (done pulse) or, with auto_reload,
// wraps to 11 and emits a borrow pulse for a higher-order stage.
module mod12_down_timer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    mod12_down_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] Q_MAX   = 4'd11;
    localparam logic [7:0] TICK_AT = 8'(PRESCALE - 1);

    state_t     state, state_nxt;
    logic [3:0] q_r, q_nxt;
    logic [7:0] pcnt, pcnt_nxt;
    logic       bout_r, bout_nxt;
    logic       done_r, done_nxt;
    logic       busy_r;
    logic       tick;
    logic [3:0] d_clamped;

    assign tick      = (pcnt == TICK_AT);
    assign d_clamped = (bus.d > Q_MAX) ? Q_MAX : bus.d;

    // Next-state, count and pulse logic; load > stop > start in every state.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        pcnt_nxt  = pcnt;
        bout_nxt  = 1'b0;
        done_nxt  = 1'b0;

        if (bus.load) begin
            q_nxt     = d_clamped;
            pcnt_nxt  = 8'd0;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.stop && bus.start) begin
                        state_nxt = RUN;
                        pcnt_nxt  = 8'd0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // Freeze q and pcnt; a coincident tick is dropped.
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        pcnt_nxt = 8'd0;
                        if (q_r != 4'd0) begin
                            q_nxt = q_r - 4'd1;
                        end else if (bus.auto_reload) begin
                            q_nxt    = Q_MAX;
                            bout_nxt = 1'b1;
                        end else begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        pcnt_nxt = pcnt + 8'd1;
                    end
                end
                PAUSE: begin
                    // pcnt is kept, so the partially elapsed step is honoured.
                    if (!bus.stop && bus.start) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else if (bus.start) begin
                        state_nxt = RUN;
                        q_nxt     = Q_MAX;
                        pcnt_nxt  = 8'd0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q_r    <= 4'd0;
            pcnt   <= 8'd0;
            bout_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            pcnt   <= pcnt_nxt;
            bout_r <= bout_nxt;
            done_r <= done_nxt;
            busy_r <= (state_nxt == RUN);
        end
    end

    assign bus.q         = q_r;
    assign bus.busy      = busy_r;
    assign bus.bout      = bout_r;
    assign bus.done      = done_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mod12_down_timer.sv
// Directed bench for mod12_down_timer: table-driven vectors on a PRESCALE=4
// instance plus hand-written multi-cycle sequences on PRESCALE=4 and =1.
module tb_mod12_down_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mod12_down_timer_if a_if ();
    mod12_down_timer_if b_if ();

    mod12_down_timer #(.PRESCALE(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mod12_down_timer #(.PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       load;
        logic [3:0] d;
        logic       start;
        logic       stop;
        logic       ar;
        logic [3:0] eq;
        logic       ebusy;
        logic       ebout;
        logic       edone;
        string      name;
    } vec_t;

    vec_t vecs[17];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic l, input logic [3:0] dd, input logic s,
                           input logic p, input logic ar);
        a_if.load = l; a_if.d = dd; a_if.start = s; a_if.stop = p; a_if.auto_reload = ar;
    endtask

    task automatic drive_b(input logic l, input logic [3:0] dd, input logic s,
                           input logic p, input logic ar);
        b_if.load = l; b_if.d = dd; b_if.start = s; b_if.stop = p; b_if.auto_reload = ar;
    endtask

    // Advance one clock edge and settle for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string name, input logic [3:0] eq, input logic eb,
                           input logic ebo, input logic ed);
        check({name, ".q"},    8'(a_if.q),    8'(eq));
        check({name, ".busy"}, 8'(a_if.busy), 8'(eb));
        check({name, ".bout"}, 8'(a_if.bout), 8'(ebo));
        check({name, ".done"}, 8'(a_if.done), 8'(ed));
    endtask

    task automatic check_b(input string name, input logic [3:0] eq, input logic eb,
                           input logic ebo, input logic ed);
        check({name, ".q"},    8'(b_if.q),    8'(eq));
        check({name, ".busy"}, 8'(b_if.busy), 8'(eb));
        check({name, ".bout"}, 8'(b_if.bout), 8'(ebo));
        check({name, ".done"}, 8'(b_if.done), 8'(ed));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Vectors for the PRESCALE=4 instance, one edge each, starting in IDLE q=0.
        //          load  d      start stop  ar    q      busy  bout  done
        vecs[0]  = '{1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "clamp_d14"};
        vecs[1]  = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "load_d11"};
        vecs[2]  = '{1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "idle_start_stop"};
        vecs[3]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, "load_d3"};
        vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, "start_run"};
        vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, "run_pcnt1"};
        vecs[6]  = '{1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, "run_load_stop_start"};
        vecs[7]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, "load_d0"};
        vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, "start_at_zero"};
        vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, "zero_wait1"};
        vecs[10] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, "zero_wait2"};
        vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, "zero_wait3"};
        vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, "zero_done"};
        vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, "done_hold"};
        vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, "done_restart"};
        vecs[15] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "run_stop"};
        vecs[16] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "pause_hold"};

        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        step();
        step();
        check_a("reset_a", 4'd0, 1'b0, 1'b0, 1'b0);
        check_b("reset_b", 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset_a.state", 8'(a_if.state_dbg), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            drive_a(vecs[i].load, vecs[i].d, vecs[i].start, vecs[i].stop, vecs[i].ar);
            step();
            check_a(vecs[i].name, vecs[i].eq, vecs[i].ebusy, vecs[i].ebout, vecs[i].edone);
        end

        // Countdown from 5 with PRESCALE=4, auto_reload=0.
        drive_a(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_a("cd_start", 4'd5, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) exp_q.push_back((k / 4 >= 5) ? 4'd0 : 4'(5 - k / 4));
        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            logic [3:0] e;
            step();
            e = exp_q.pop_front();
            check_a($sformatf("cd_k%0d", k), e, (k < 24), 1'b0, (k == 24));
        end
        step();
        check_a("cd_after_done", 4'd0, 1'b0, 1'b0, 1'b0);

        // Pause/resume: stop lands with pcnt=2 elapsed, so two cycles remain.
        drive_a(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive_a(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        check_a("pause_enter", 4'd9, 1'b0, 1'b0, 1'b0);
        check("pause_enter.state", 8'(a_if.state_dbg), 8'd2);
        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            check_a($sformatf("pause_k%0d", k), 4'd9, 1'b0, 1'b0, 1'b0);
        end
        drive_a(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_a("resume", 4'd9, 1'b1, 1'b0, 1'b0);
        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_a("resume_p1", 4'd9, 1'b1, 1'b0, 1'b0);
        step();
        check_a("resume_p2", 4'd8, 1'b1, 1'b0, 1'b0);

        // Wrap with PRESCALE=1 and auto_reload=1.
        drive_b(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        drive_b(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_b("wrap_q1", 4'd1, 1'b1, 1'b0, 1'b0);
        drive_b(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_b("wrap_q0", 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_b("wrap_q11", 4'd11, 1'b1, 1'b1, 1'b0);
        step();
        check_b("wrap_q10", 4'd10, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN at q=7.
        drive_a(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_a("pre_reset", 4'd7, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_a("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        check("async_reset.state", 8'(a_if.state_dbg), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_a("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_a("post_reset_idle2", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod12_down_timer.md
# mod12_down_timer

Mod-12 countdown timer with an internal step prescaler and run/pause/done control. It is the down-counting counterpart of the team's mod-12 up counter. A 4-bit value counts 11→0 at one step per PRESCALE clocks. At zero the block either finishes (done pulse) or, when auto-reload is set, wraps to 11 and emits a borrow pulse to cascade into a higher-order stage. It sits beside the up counter in the timing/sequencing datapath.

## Interface
- PRESCALE, default 4: clock cycles per count step; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  load d into q; stop the timer.
- d  input  4  load value; values 12..15 are clamped to 11.
- start  input  1  start or resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  1: wrap 0→11 and continue; 0: finish at 0.
- q  output  4  current count, always in 0..11.
- busy  output  1  high while in RUN.
- bout  output  1  one-cycle borrow pulse on a 0→11 wrap.
- done  output  1  one-cycle pulse on entry to DONE.

## Operation
- Reset value of every output: q=0, busy=0, bout=0, done=0.
- Reset value of internal state: FSM=IDLE, prescaler pcnt=0.
- FSM states: IDLE, RUN, PAUSE, DONE. busy = (state==RUN) and is registered.
- Input priority, evaluated every edge: load > stop > start.
- load, in any state:
  - q ← (d>11 ? 11 : d).
  - pcnt ← 0; state ← IDLE.
  - bout and done stay 0 that cycle.
- IDLE:
  - start → RUN, pcnt ← 0.
  - stop, or start together with stop → stay IDLE.
- RUN:
  - pcnt increments each cycle; tick = (pcnt==PRESCALE-1), and pcnt ← 0 on tick.
  - On tick with q>0: q ← q-1.
  - On tick with q==0 and auto_reload=1: q ← 11, bout ← 1, stay RUN.
  - On tick with q==0 and auto_reload=0: state ← DONE, done ← 1, q stays 0.
  - stop → PAUSE, with q and pcnt frozen. stop wins over a coincident tick: no decrement that cycle.
- PAUSE:
  - start → RUN; pcnt resumes from its frozen value, so there is no lost or extra step.
  - stop alone → stay PAUSE.
- DONE:
  - q holds 0.
  - start → RUN with q ← 11 and pcnt ← 0.
  - stop → IDLE.
- auto_reload is sampled only on the tick at q==0 and may change at any time.
- Arithmetic: q is 4 bits and never leaves 0..11. pcnt is 8 bits. PRESCALE=1 means tick every RUN cycle.
- Reset asserted mid-count forces the reset values immediately, without waiting for clk. On release, the block waits in IDLE.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- start sampled at edge N (from IDLE): busy=1 after N. First decrement is visible after edge N+PRESCALE, then one decrement every PRESCALE cycles.
- Full countdown from q=11: done is visible after edge N+12·PRESCALE and busy drops at the same edge.
- bout and done are high for exactly one cycle and never overlap.
- Resume from PAUSE: the remaining cycles to the next step equal PRESCALE minus the pcnt count already elapsed before the stop.
- load to q visible: 1 cycle.
- Reset deassertion must meet recovery time to clk. The first functional edge after release sees IDLE.

## Test plan
- Reset mid-RUN (q=7): assert rst low between edges → q=0, busy=0, bout=0, done=0 before the next edge; block idles after release.
- PRESCALE=4, load d=5, start at edge N, auto_reload=0:
  - q=4,3,2,1,0 after edges N+4, N+8, N+12, N+16, N+20.
  - done pulse after edge N+24, then busy=0 and q=0.
- Load clamp: d=14 → q=11. d=11 → q=11. d=0 then start, auto_reload=0 → DONE after PRESCALE cycles, no bout.
- Wrap with PRESCALE=1, auto_reload=1, load 1, start:
  - q=1,0,11,10 on successive cycles.
  - bout high exactly in the cycle q becomes 11; done never asserts.
- Pause/resume with PRESCALE=4, load 9, start:
  - Assert stop 2 cycles after start → q stays 9 for 10 cycles.
  - start again → q=8 two cycles later.
- Priority:
  - load+stop+start in RUN → IDLE with q=d.
  - start+stop in IDLE → stays IDLE.
  - start in DONE → q=11, busy=1, countdown restarts.
